// File: rtl/command_driver_pkg.sv
// command_driver_pkg: shared types, command codes, driver states and block-length helper
package command_driver_pkg;

    typedef logic        ulogic1;
    typedef logic [1:0]  ulogic2;
    typedef logic [2:0]  ulogic3;
    typedef logic [15:0] ulogic16;
    typedef logic [24:0] ulogic25;

    localparam ulogic3 CMD_NOP       = 3'd0;
    localparam ulogic3 CMD_SCALAR_RD = 3'd1;
    localparam ulogic3 CMD_SCALAR_WR = 3'd2;
    localparam ulogic3 CMD_BLOCK_RD  = 3'd3;
    localparam ulogic3 CMD_BLOCK_WR  = 3'd4;
    localparam ulogic3 CMD_ATOMIC_RD = 3'd5;
    localparam ulogic3 CMD_ATOMIC_WR = 3'd6;
    localparam ulogic3 CMD_NOP7      = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, BLK_DATA} drv_state_e;

    // Number of data words a block write of size code sz transfers.
    function automatic int unsigned blk_words(input ulogic2 sz, input int unsigned unit);
        return unit * (int'(sz) + 1);
    endfunction

endpackage

// File: rtl/command_driver.sv
// command_driver: issues abstract requests as DDR2 controller commands and streams block-write data
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/ready/...   : stimulus request port (cmd, sz, op, addr, data)
//   wd_valid/ready/data   : block-write data stream
//   ready, fetching       : controller command acceptance and data consumption
//   cmd/sz/op/din/addr    : registered command bus to the controller
//   busy, underrun        : driver not idle; sticky fetch-without-data flag
//   issued_cnt            : wrapping count of issued commands
module command_driver
    import command_driver_pkg::*;
#(
    parameter int BLK_UNIT = 8,
    parameter int CNT_W    = 16
) (
    input  ulogic1             clk,
    input  ulogic1             reset,
    input  ulogic1             req_valid,
    output ulogic1             req_ready,
    input  ulogic3             req_cmd,
    input  ulogic2             req_sz,
    input  ulogic3             req_op,
    input  ulogic25            req_addr,
    input  ulogic16            req_data,
    input  ulogic1             wd_valid,
    output ulogic1             wd_ready,
    input  ulogic16            wd_data,
    input  ulogic1             ready,
    input  ulogic1             fetching,
    output ulogic3             cmd,
    output ulogic2             sz,
    output ulogic3             op,
    output ulogic16            din,
    output ulogic25            addr,
    output ulogic1             busy,
    output ulogic1             underrun,
    output logic [CNT_W-1:0]   issued_cnt
);

    localparam int WC_W = $clog2(4 * BLK_UNIT + 1);

    drv_state_e        state_q, state_d;
    ulogic3            cmd_q, cmd_d, op_q, op_d;
    ulogic2            sz_q, sz_d;
    ulogic16           din_q, din_d;
    ulogic25           addr_q, addr_d;
    ulogic1            din_vld_q, din_vld_d, underrun_q, underrun_d;
    logic [WC_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Handshakes are held low while reset is asserted so nothing is accepted or popped.
    assign req_ready  = !reset && ready && state_q == IDLE;
    assign wd_ready   = !reset && state_q == BLK_DATA &&
                        (!din_vld_q || (fetching && rem_q > WC_W'(1)));
    assign cmd        = cmd_q;
    assign sz         = sz_q;
    assign op         = op_q;
    assign din        = din_q;
    assign addr       = addr_q;
    assign busy       = state_q != IDLE;
    assign underrun   = underrun_q;
    assign issued_cnt = cnt_q;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        sz_d       = sz_q;
        op_d       = op_q;
        din_d      = din_q;
        addr_d     = addr_q;
        din_vld_d  = din_vld_q;
        underrun_d = underrun_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        if (state_q == IDLE) begin
            cmd_d = CMD_NOP;
            // Codes 0 and 7 are consumed without touching the bus.
            if (req_valid && req_ready && req_cmd != CMD_NOP && req_cmd != CMD_NOP7) begin
                state_d = ISSUE;
                cmd_d   = req_cmd;
                sz_d    = req_sz;
                op_d    = req_op;
                addr_d  = req_addr;
                din_d   = (req_cmd == CMD_SCALAR_WR || req_cmd == CMD_ATOMIC_RD ||
                           req_cmd == CMD_ATOMIC_WR) ? req_data : '0;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else if (state_q == ISSUE) begin
            cmd_d   = CMD_NOP;
            state_d = (cmd_q == CMD_BLOCK_WR) ? BLK_DATA : IDLE;
            if (cmd_q == CMD_BLOCK_WR) begin
                rem_d     = WC_W'(blk_words(sz_q, BLK_UNIT));
                din_vld_d = 1'b0;
            end
        end else begin
            // A pop in the same cycle as a fetch replaces the word being fetched.
            if (wd_valid && wd_ready) begin
                din_d     = wd_data;
                din_vld_d = 1'b1;
            end else if (fetching) begin
                din_vld_d = 1'b0;
            end
            if (fetching) begin
                rem_d      = rem_q - WC_W'(1);
                underrun_d = underrun_q || !din_vld_q;
                if (rem_q == WC_W'(1)) begin
                    state_d   = IDLE;
                    din_d     = '0;
                    din_vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            sz_q       <= '0;
            op_q       <= '0;
            din_q      <= '0;
            addr_q     <= '0;
            din_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            sz_q       <= sz_d;
            op_q       <= op_d;
            din_q      <= din_d;
            addr_q     <= addr_d;
            din_vld_q  <= din_vld_d;
            underrun_q <= underrun_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_command_driver.sv
// tb_command_driver: directed self-checking bench for command_driver
module tb_command_driver;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, wd_valid, wd_ready, ready, fetching;
    logic [2:0]  req_cmd, req_op, cmd, op;
    logic [1:0]  req_sz, sz;
    logic [24:0] req_addr, addr;
    logic [15:0] req_data, wd_data, din;
    logic        busy, underrun;
    logic [15:0] issued_cnt;

    int total = 0;
    int bad   = 0;
    int pops, fetched;

    command_driver #(.BLK_UNIT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_sz(req_sz),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .ready(ready), .fetching(fetching),
        .cmd(cmd), .sz(sz), .op(op), .din(din), .addr(addr),
        .busy(busy), .underrun(underrun), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ready = 1'b1; req_valid = 1'b1; req_cmd = 3'd2; req_sz = 2'd0;
        req_op = 3'd0; req_addr = 25'h0; req_data = 16'h0;
        wd_valid = 1'b0; wd_data = 16'h0; fetching = 1'b0;
        #2;
        chk("rst_cmd", cmd, 0);
        chk("rst_din", din, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", issued_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        tick();
        chk("rst_hold_cmd", cmd, 0);
        chk("rst_hold_req_ready", req_ready, 0);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        // scalar write
        req_valid = 1'b1; req_cmd = 3'd2; req_addr = 25'h0ABCDE; req_data = 16'h1234;
        tick();
        req_valid = 1'b0;
        chk("sw_cmd", cmd, 2);
        chk("sw_addr", addr, 25'h0ABCDE);
        chk("sw_din", din, 16'h1234);
        chk("sw_cnt", issued_cnt, 1);
        chk("sw_busy", busy, 1);
        chk("sw_req_ready", req_ready, 0);
        tick();
        chk("sw_cmd_back", cmd, 0);
        chk("sw_busy_back", busy, 0);

        // back-pressure, then atomic read
        ready = 1'b0; req_valid = 1'b1; req_cmd = 3'd5; req_sz = 2'd2; req_op = 3'd3;
        req_addr = 25'h1000003; req_data = 16'hBEEF;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_req_ready", req_ready, 0);
            tick();
            chk("bp_cmd", cmd, 0);
        end
        ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("ar_cmd", cmd, 5);
        chk("ar_din", din, 16'hBEEF);
        chk("ar_sz", sz, 2);
        chk("ar_op", op, 3);
        chk("ar_addr", addr, 25'h1000003);
        chk("ar_cnt", issued_cnt, 2);
        tick();

        // block write sz=1: 16 words, fetching on two of every three cycles
        req_valid = 1'b1; req_cmd = 3'd4; req_sz = 2'd1; req_op = 3'd0; req_addr = 25'h0001000;
        tick();
        req_valid = 1'b0;
        chk("bw16_cmd", cmd, 4);
        chk("bw16_din", din, 0);
        chk("bw16_cnt", issued_cnt, 3);
        tick();
        chk("bw16_cmd_idle", cmd, 0);
        chk("bw16_busy", busy, 1);
        pops = 0; fetched = 0;
        for (int c = 0; c < 100 && fetched < 16; c++) begin
            wd_valid = 1'b1; wd_data = 16'(pops); fetching = (c % 3 != 0);
            #1;
            if (fetching) chk("bw16_word", din, fetched);
            if (wd_valid && wd_ready) pops++;
            if (fetching) fetched++;
            tick();
        end
        chk("bw16_fetches", fetched, 16);
        chk("bw16_pops", pops, 16);
        chk("bw16_busy_end", busy, 0);
        chk("bw16_din_end", din, 0);
        chk("bw16_underrun", underrun, 0);
        chk("bw16_wd_ready_end", wd_ready, 0);
        wd_valid = 1'b0; fetching = 1'b0;

        // block write sz=0 with a data gap forcing an underrun on the 3rd fetch
        req_valid = 1'b1; req_cmd = 3'd4; req_sz = 2'd0;
        tick();
        req_valid = 1'b0;
        chk("bw8_cnt", issued_cnt, 4);
        tick();
        fetched = 0;
        for (int c = 0; c < 60 && fetched < 8; c++) begin
            wd_valid = !(c == 3 || c == 4); wd_data = 16'(c); fetching = (c % 2 == 1);
            #1;
            if (fetching) fetched++;
            tick();
            chk("bw8_underrun", underrun, fetched >= 3);
        end
        chk("bw8_fetches", fetched, 8);
        chk("bw8_busy_end", busy, 0);
        wd_valid = 1'b0; fetching = 1'b0;
        tick();
        chk("bw8_underrun_sticky", underrun, 1);

        // code 7 is consumed silently
        req_valid = 1'b1; req_cmd = 3'd7;
        #1;
        chk("nop7_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("nop7_cmd", cmd, 0);
        chk("nop7_busy", busy, 0);
        chk("nop7_cnt", issued_cnt, 4);
        tick();
        chk("nop7_cmd2", cmd, 0);

        // block write sz=3 aborted by reset after 4 fetches
        req_valid = 1'b1; req_cmd = 3'd4; req_sz = 2'd3;
        tick();
        req_valid = 1'b0;
        chk("bw32_cmd", cmd, 4);
        chk("bw32_cnt", issued_cnt, 5);
        tick();
        pops = 0; fetched = 0;
        for (int c = 0; c < 20 && fetched < 4; c++) begin
            wd_valid = 1'b1; wd_data = 16'hA000 + 16'(c); fetching = (c > 0);
            #1;
            if (wd_valid && wd_ready) pops++;
            if (fetching) fetched++;
            tick();
        end
        chk("bw32_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wd_ready", wd_ready, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_cnt", issued_cnt, 0);
        chk("abort_underrun", underrun, 0);
        chk("abort_sz", sz, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (wd_valid && wd_ready) pops++;
            tick();
        end
        reset = 1'b0; ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (wd_valid && wd_ready) pops++;
            tick();
        end
        chk("abort_pops", pops, 5);
        chk("abort_wd_ready_after", wd_ready, 0);
        chk("abort_cmd_after", cmd, 0);
        wd_valid = 1'b0; fetching = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/command_driver.md
Name: command_driver

Overview:
- Initiator for the DDR2 controller command bus.
- Accepts abstract transactions from the stimulus side on a valid/ready request port, plus a separate block-write data stream.
- Drives cmd/sz/op/addr/din to the DDR2 controller one command at a time, honouring controller `ready`. During block writes it streams data words paced by controller `fetching`.
- Sits between the stimulus generator and the DDR2 controller; command_monitor observes its outputs.

Parameters:
- BLK_UNIT, 8, words per size step; a block write transfers BLK_UNIT*(sz+1) words.
- CNT_W, 16, width of the issued-command counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  stimulus transaction valid
- req_ready  out  1  driver accepts transaction this cycle
- req_cmd  in  3  command code 0..7
- req_sz  in  2  size field
- req_op  in  3  atomic op field
- req_addr  in  25  bank [4:3], row [24:12], column {[11:5],[2:0]}
- req_data  in  16  write data for scalar/atomic commands
- wd_valid  in  1  block-write data word valid
- wd_ready  out  1  driver pops block-write word this cycle
- wd_data  in  16  block-write data word
- ready  in  1  controller can accept a command
- fetching  in  1  controller consumes `din` this cycle (block write)
- cmd  out  3  command to controller
- sz  out  2  size to controller
- op  out  3  op to controller
- din  out  16  data to controller
- addr  out  25  address to controller
- busy  out  1  state != IDLE
- underrun  out  1  sticky: controller fetched with no valid word loaded
- issued_cnt  out  CNT_W  commands issued (wraps)

Behaviour:
- Clocking and reset
  - All outputs are registered except req_ready and wd_ready.
  - Reset, asynchronous: state=IDLE; cmd=0, sz=0, op=0, din=0, addr=0, busy=0, underrun=0, issued_cnt=0; word counter and din_vld cleared.
  - Reset mid-block-write aborts the transfer immediately. No remaining words are popped.
- States: IDLE, ISSUE, BLK_DATA.
- IDLE
  - cmd=NOP(0).
  - req_ready = ready && state==IDLE (combinational).
  - On req_valid && req_ready, the request fields are registered onto cmd/sz/op/addr.
  - din = req_data for cmd 2, 5, 6; din = 0 otherwise.
  - State goes to ISSUE; issued_cnt increments.
- Request cmd 0 or 7
  - Accepted and consumed.
  - No command issued, issued_cnt unchanged, state stays IDLE.
- ISSUE (exactly 1 cycle, command visible on the bus)
  - Next cycle cmd returns to 0.
  - If the issued cmd is 4 (block write): go to BLK_DATA, load word count N = BLK_UNIT*(sz+1), clear din_vld.
  - Otherwise: go to IDLE. Minimum spacing between commands is therefore 2 cycles.
- BLK_DATA
  - cmd=0, sz/op/addr held.
  - wd_ready = !din_vld || (fetching && remaining>1).
  - On wd_valid && wd_ready: din<=wd_data, din_vld<=1.
  - On fetching:
    - remaining decrements.
    - If !din_vld, underrun<=1 (sticky until reset); the word still counts.
    - din_vld clears unless a new word is popped in the same cycle.
  - When remaining reaches 0 after a fetch: go to IDLE, din<=0. Any words still queued in the wd stream are left unpopped.
  - Simultaneous fetching and pop in the same cycle: the fetched word is the old din; the popped word becomes the new din.
- Counters
  - issued_cnt wraps modulo 2^CNT_W.
  - Word counter width is ceil(log2(4*BLK_UNIT+1)).
- Ignored inputs
  - ready is ignored outside IDLE.
  - fetching outside BLK_DATA is ignored and does not set underrun.

Decomposition:
- Shared package (definitions.sv): command constants CMD_NOP=0, CMD_SCALAR_RD=1, CMD_SCALAR_WR=2, CMD_BLOCK_RD=3, CMD_BLOCK_WR=4, CMD_ATOMIC_RD=5, CMD_ATOMIC_WR=6, CMD_NOP7=7; driver state enum; block-length function blk_words(sz, unit).
- Existing ulogicN typedefs are used for all ports.
- Single flat module; no sub-module required.

Test Plan:
- Reset:
  - Assert reset mid-cycle with req_valid=1 -> all outputs 0 immediately, req_ready=0 while reset held.
  - Release, ready=1 -> req_ready=1.
- Scalar write:
  - req_cmd=2, addr=25'h0ABCDE, data=16'h1234, ready=1 -> one cycle later cmd=2, addr=0ABCDE, din=1234 for exactly 1 cycle, then cmd=0; issued_cnt=1.
- Back-pressure:
  - ready=0 for 5 cycles with req_valid=1 -> req_ready=0, cmd stays 0.
  - ready=1 on cycle 6 -> command issued the next cycle.
- Block write, sz=1 (16 words):
  - Words 16'h0000..16'h000F available, fetching pulsed 16 times at arbitrary spacing -> din presents the words in order, 16 pops, underrun=0, busy drops after the 16th fetch.
- Underrun:
  - Block write sz=0, wd_valid=0 at the 3rd fetch -> underrun=1 and stays 1.
  - Transfer completes after 8 fetches.
- Illegal/NOP request and reset abort:
  - req_cmd=7 -> consumed, no bus activity, issued_cnt unchanged.
  - Reset after 4 of 32 block words -> state IDLE, wd_ready=0, no further pops.
